fft_result_fifo_if: RTL and testbench
=====================================

Name: fft_result_fifo_if

Overview:
- Parametrised successor to the single-register FFT result driver interface.
- Buffers a stream of FFT output words in a DEPTH-entry FIFO and tags frame boundaries.
- Exposes data, status, control and frame-count registers on a 50 MHz memory-mapped slave bus for the audio driver.
- Sits between the FFT core's streaming source port and the HPS bridge.

Parameters:
- DATA_SIZE, 28, width of each FFT result word (1..30).
- DEPTH, 16, FIFO entries; power of two, 2..1024.
- IRQ_LEVEL, 8, fill level at or above which irq asserts (1..DEPTH); used only with the optional feature.

Ports:
- clk  input  1  system clock, 50 MHz
- reset  input  1  synchronous, active-high
- chipselect  input  1  slave select
- address  input  2  register select
- read  input  1  read strobe
- write  input  1  write strobe
- write_data  input  32  write data
- read_data  output  32  registered read data
- source_valid  input  1  FFT word valid
- source_data  input  DATA_SIZE  FFT word
- source_eop  input  1  last word of FFT frame
- source_ready  output  1  FIFO can accept a word
- irq  output  1  fill-level interrupt

Behaviour:
- Clocking and reset: clk; reset is synchronous, active-high.
- Reset state: FIFO empty, count=0, overflow=0, frame_cnt=0, irq_enable=0, read_data=0, irq=0, source_ready=1.
- Push: occurs when source_valid && source_ready.
  - Stores {source_eop, source_data}.
  - On an accepted word with source_eop=1, frame_cnt increments (16-bit, wraps 0xFFFF->0).
- source_ready = !full, taken combinationally from registered state. A pop in the same cycle does not open a slot for a push while full.
- Overflow: source_valid && !source_ready sets the sticky overflow bit. The word is not stored; the producer is expected to hold it.
- Bus read: read_data is updated one cycle after chipselect && read (1-cycle latency) and holds its value otherwise.
- Address map:
  - 0 DATA (read pops):
    - Non-empty: read_data = {1 valid, eop, zero-pad, data}, i.e. bit31=1, bit30=eop, [DATA_SIZE-1:0]=data; pops head.
    - Empty: read_data=0, no pop, no state change.
  - 1 STATUS (read, no side effect): [15:0]=count zero-extended, bit16=empty, bit17=full, bit18=overflow, bit19=irq_enable; other bits 0.
  - 2 CONTROL:
    - Write bit0=1 clears overflow.
    - Write bit1=1 flushes the FIFO (count=0, pointers=0; frame_cnt unchanged).
    - Write bit2 stores irq_enable.
    - Read returns {29'b0, irq_enable, 2'b0}.
  - 3 FRAMES: read returns {16'b0, frame_cnt}. Any write to 3 clears frame_cnt.
- Simultaneous events:
  - Push and pop in the same cycle on a non-empty, non-full FIFO: count unchanged; both take effect.
  - Push into an empty FIFO and a DATA read in the same cycle: read returns 0 (empty); the new word remains.
  - Flush and push in the same cycle: flush wins, the pushed word is discarded, frame_cnt still counts its eop, overflow unaffected.
  - Overflow set and clear in the same cycle: set wins.
  - Write to 3 and an accepted eop in the same cycle: frame_cnt becomes 0.
  - read and write both asserted: the write takes effect and read_data is updated per the read rule.
- Pointers: wrap modulo DEPTH. count has range 0..DEPTH and width $clog2(DEPTH)+1.
- Reset mid-frame: all contents are discarded, with no partial-frame recovery.

Optional Feature:
- Macro: FFT_FIFO_IRQ_EN.
- Defined: irq is registered and equals irq_enable && (count >= IRQ_LEVEL), computed from post-update count; it deasserts the cycle after count drops below IRQ_LEVEL.
- Undefined: irq is tied to 0 and no comparator logic is generated. STATUS bit19 and CONTROL bit2 still read back irq_enable.

Test Plan:
- Reset, then push 0x0000123 (eop=0) and read addr0 -> next cycle read_data=0x80000123, then STATUS count=0, empty=1.
- Push DEPTH=16 words 1..16 with the last word eop=1 -> source_ready=0 after the 16th; STATUS=0x00020010; FRAMES=1; 16 DATA reads return 0x80000001..0x8000000F then 0xC0000010.
- With the FIFO full, hold source_valid one cycle -> STATUS bit18=1. Write CONTROL 0x1 -> bit18=0. Repeat with clear and overflow in the same cycle -> bit18 stays 1.
- Fill 5 words, then read DATA while pushing every cycle for 10 cycles -> count stays 5; the read sequence is FIFO order with no loss. Read DATA when empty -> 0x00000000 and count stays 0.
- Fill 7 words, write CONTROL 0x2 concurrently with a push -> count=0, empty=1, source_ready=1; FRAMES unchanged except for an eop on the dropped word.
- FFT_FIFO_IRQ_EN defined, IRQ_LEVEL=8, CONTROL=0x4: push 8 words -> irq=1 the cycle after the 8th; one DATA read -> irq=0 next cycle. Macro undefined -> irq stays 0 throughout.

Source files
------------

// File: rtl/fft_result_fifo_if.sv
// FFT result FIFO with a memory-mapped slave register interface.
// Optional fill-level interrupt is built when FFT_FIFO_IRQ_EN is defined.
module fft_result_fifo_if #(
  parameter int DATA_SIZE = 28,
  parameter int DEPTH     = 16,
  parameter int IRQ_LEVEL = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 chipselect,
  input  logic [1:0]           address,
  input  logic                 read,
  input  logic                 write,
  input  logic [31:0]          write_data,
  output logic [31:0]          read_data,
  input  logic                 source_valid,
  input  logic [DATA_SIZE-1:0] source_data,
  input  logic                 source_eop,
  output logic                 source_ready,
  output logic                 irq
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    ADDR_DATA    = 2'd0,
    ADDR_STATUS  = 2'd1,
    ADDR_CONTROL = 2'd2,
    ADDR_FRAMES  = 2'd3
  } reg_addr_t;

  logic [DATA_SIZE:0] mem [DEPTH];
  logic [DATA_SIZE:0] head;
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [AW:0]        count, count_next;
  logic               overflow, irq_enable;
  logic [15:0]        frame_cnt;
  logic [31:0]        rd_word;

  logic full, empty, bus_rd, bus_wr, ctrl_wr;
  logic push, pop, flush, ovf_set, ovf_clear, frames_clear;

  assign full         = (count == FULL_COUNT);
  assign empty        = (count == '0);
  assign source_ready = !full;

  assign bus_rd       = chipselect && read;
  assign bus_wr       = chipselect && write;
  assign ctrl_wr      = bus_wr && (reg_addr_t'(address) == ADDR_CONTROL);
  assign push         = source_valid && !full;
  assign pop          = bus_rd && (reg_addr_t'(address) == ADDR_DATA) && !empty;
  assign flush        = ctrl_wr && write_data[1];
  assign ovf_set      = source_valid && full;
  assign ovf_clear    = ctrl_wr && write_data[0];
  assign frames_clear = bus_wr && (reg_addr_t'(address) == ADDR_FRAMES);
  assign head         = mem[rd_ptr];

  always_comb begin
    // NOTE: default assigned first so no path through this block infers a latch.
    count_next = count;
    if (flush) begin
      count_next = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_next = count + 1'b1;
        2'b01:   count_next = count - 1'b1;
        default: count_next = count;
      endcase
    end
  end

  always_comb begin
    rd_word = '0;
    case (reg_addr_t'(address))
      ADDR_DATA: begin
        if (!empty) begin
          rd_word[DATA_SIZE-1:0] = head[DATA_SIZE-1:0];
          rd_word[30]            = head[DATA_SIZE];
          rd_word[31]            = 1'b1;
        end
      end
      ADDR_STATUS: begin
        rd_word[AW:0] = count;
        rd_word[16]   = empty;
        rd_word[17]   = full;
        rd_word[18]   = overflow;
        rd_word[19]   = irq_enable;
      end
      ADDR_CONTROL: rd_word[2]    = irq_enable;
      ADDR_FRAMES:  rd_word[15:0] = frame_cnt;
      default:      rd_word       = '0;
    endcase
  end

  // NOTE: storage array has no reset; validity is tracked by count/pointers alone.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= {source_eop, source_data};
    end
  end

  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      frame_cnt  <= '0;
      irq_enable <= 1'b0;
      read_data  <= '0;
    end else begin
      count <= count_next;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
      // A new overflow in the same cycle as a clear must not be lost.
      overflow <= ovf_set || (overflow && !ovf_clear);
      if (frames_clear) begin
        frame_cnt <= '0;
      end else if (push && source_eop) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
      if (ctrl_wr) irq_enable <= write_data[2];
      if (bus_rd)  read_data  <= rd_word;
    end
  end

`ifdef FFT_FIFO_IRQ_EN
  localparam logic [AW:0] IRQ_THRESH = (AW+1)'(IRQ_LEVEL);
  logic irq_enable_next;

  assign irq_enable_next = ctrl_wr ? write_data[2] : irq_enable;

  always_ff @(posedge clk) begin
    if (reset) begin
      irq <= 1'b0;
    end else begin
      irq <= irq_enable_next && (count_next >= IRQ_THRESH);
    end
  end
`else
  logic [31:0] unused_irq_level;
  assign unused_irq_level = IRQ_LEVEL;
  assign irq              = 1'b0;
`endif

  logic unused_write_bits;
  assign unused_write_bits = ^write_data[31:3];

endmodule

// File: tb/tb_fft_result_fifo_if.sv
// Self-checking bench for fft_result_fifo_if: directed literal checks plus
// randomized traffic compared each cycle against a queue-based reference model.
module tb_fft_result_fifo_if;

  localparam int DATA_SIZE = 28;
  localparam int DEPTH     = 16;
  localparam int IRQ_LEVEL = 8;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 chipselect, read, write;
  logic [1:0]           address;
  logic [31:0]          write_data;
  logic [31:0]          read_data;
  logic                 source_valid;
  logic [DATA_SIZE-1:0] source_data;
  logic                 source_eop;
  logic                 source_ready;
  logic                 irq;

  fft_result_fifo_if #(
    .DATA_SIZE(DATA_SIZE),
    .DEPTH    (DEPTH),
    .IRQ_LEVEL(IRQ_LEVEL)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .chipselect  (chipselect),
    .address     (address),
    .read        (read),
    .write       (write),
    .write_data  (write_data),
    .read_data   (read_data),
    .source_valid(source_valid),
    .source_data (source_data),
    .source_eop  (source_eop),
    .source_ready(source_ready),
    .irq         (irq)
  );

  always #10 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

`ifdef FFT_FIFO_IRQ_EN
  localparam logic IRQ_BUILT = 1'b1;
`else
  localparam logic IRQ_BUILT = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Reference model: FIFO contents as a queue, registers as plain variables.
  logic [DATA_SIZE:0] q[$];
  logic        m_ovf, m_ien, m_irq, m_ok = 1'b0;
  logic [15:0] m_frames;
  logic [31:0] m_rd;

  task automatic model_step();
    int n;
    logic full_pre, empty_pre, ctrl;
    logic [DATA_SIZE:0] w;
    if (reset) begin
      q.delete();
      m_ovf = 0; m_ien = 0; m_irq = 0; m_frames = 0; m_rd = 0; m_ok = 1;
      return;
    end
    n = q.size();
    full_pre  = (n == DEPTH);
    empty_pre = (n == 0);
    ctrl = chipselect && write && (address == 2'd2);
    if (chipselect && read) begin
      case (address)
        2'd0: begin
          if (empty_pre) m_rd = 0;
          else begin
            w = q.pop_front();
            m_rd = 32'h8000_0000 | (32'(w[DATA_SIZE]) << 30) | 32'(w[DATA_SIZE-1:0]);
          end
        end
        2'd1: m_rd = 32'(n) | (32'(empty_pre) << 16) | (32'(full_pre) << 17)
                     | (32'(m_ovf) << 18) | (32'(m_ien) << 19);
        2'd2: m_rd = 32'(m_ien) << 2;
        default: m_rd = 32'(m_frames);
      endcase
    end
    if (source_valid && !full_pre) begin
      q.push_back({source_eop, source_data});
      if (source_eop) m_frames = m_frames + 16'd1;
    end
    if (ctrl) begin
      if (write_data[0]) m_ovf = 0;
      if (write_data[1]) q.delete();
      m_ien = write_data[2];
    end
    if (source_valid && full_pre) m_ovf = 1;
    if (chipselect && write && (address == 2'd3)) m_frames = 0;
    m_irq = IRQ_BUILT && m_ien && (q.size() >= IRQ_LEVEL);
  endtask

  always @(posedge clk) model_step();

  always @(negedge clk) begin
    if (m_ok) begin
      check("read_data", read_data, m_rd);
      check("source_ready", 32'(source_ready), 32'(q.size() < DEPTH));
      check("irq", 32'(irq), 32'(m_irq));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    chipselect = 0; read = 0; write = 0; address = 0; write_data = 0;
    source_valid = 0; source_data = 0; source_eop = 0;
  endtask

  task automatic bus(input logic rd, input logic wr, input logic [1:0] a, input logic [31:0] wd,
                     input logic sv, input logic [DATA_SIZE-1:0] sd, input logic eop);
    chipselect = rd | wr; read = rd; write = wr; address = a; write_data = wd;
    source_valid = sv; source_data = sd; source_eop = eop;
    tick();
    set_idle();
  endtask

  task automatic push_word(input logic [DATA_SIZE-1:0] sd, input logic eop);
    bus(0, 0, 2'd0, 0, 1, sd, eop);
  endtask

  task automatic read_expect(input string name, input logic [1:0] a, input logic [31:0] exp);
    bus(1, 0, a, 0, 0, 0, 0);
    check(name, read_data, exp);
  endtask

  initial begin
    set_idle();
    reset = 1;
    repeat (3) tick();
    check("reset read_data", read_data, 32'h0);
    check("reset source_ready", 32'(source_ready), 32'h1);
    check("reset irq", 32'(irq), 32'h0);
    reset = 0;
    read_expect("reset status", 2'd1, 32'h0001_0000);

    // Single word round trip.
    push_word(28'h000_0123, 0);
    read_expect("single pop", 2'd0, 32'h8000_0123);
    read_expect("single status", 2'd1, 32'h0001_0000);

    // Fill to DEPTH with a frame ending on the last word.
    for (int i = 1; i <= DEPTH; i++) push_word(DATA_SIZE'(i), i == DEPTH);
    check("full ready", 32'(source_ready), 32'h0);
    read_expect("full status", 2'd1, 32'h0002_0010);
    read_expect("frames one", 2'd3, 32'h0000_0001);
    for (int i = 1; i <= DEPTH; i++)
      read_expect("drain order", 2'd0, (i == DEPTH) ? 32'hC000_0010 : (32'h8000_0000 | 32'(i)));

    // Overflow set, clear, and set-wins-over-clear.
    for (int i = 0; i < DEPTH; i++) push_word(DATA_SIZE'(32'h40 + i), 0);
    push_word(28'h0AB_CDEF, 0);
    read_expect("ovf set", 2'd1, 32'h0006_0010);
    bus(0, 1, 2'd2, 32'h1, 0, 0, 0);
    read_expect("ovf cleared", 2'd1, 32'h0002_0010);
    bus(0, 1, 2'd2, 32'h1, 1, 28'h0AB_CDEF, 0);
    read_expect("ovf set wins", 2'd1, 32'h0006_0010);
    bus(0, 1, 2'd2, 32'h3, 0, 0, 0);
    read_expect("ovf clear flush", 2'd1, 32'h0001_0000);

    // Concurrent push and pop keeps count steady and order intact.
    for (int i = 0; i < 5; i++) push_word(DATA_SIZE'(32'h100 + i), 0);
    for (int i = 0; i < 10; i++) begin
      bus(1, 0, 2'd0, 0, 1, DATA_SIZE'(32'h200 + i), 0);
      check("stream order", read_data,
            32'h8000_0000 | ((i < 5) ? 32'(32'h100 + i) : 32'(32'h200 + i - 5)));
    end
    read_expect("stream count", 2'd1, 32'h0000_0005);
    for (int i = 5; i < 10; i++) read_expect("stream tail", 2'd0, 32'h8000_0000 | 32'(32'h200 + i));
    read_expect("empty pop", 2'd0, 32'h0);
    read_expect("empty status", 2'd1, 32'h0001_0000);

    // Flush concurrent with an eop push: word dropped, frame still counted.
    for (int i = 0; i < 7; i++) push_word(DATA_SIZE'(i), 0);
    bus(0, 1, 2'd2, 32'h2, 1, 28'h0FF_FFFF, 1);
    read_expect("flush status", 2'd1, 32'h0001_0000);
    check("flush ready", 32'(source_ready), 32'h1);
    read_expect("flush frames", 2'd3, 32'h0000_0002);

    // Interrupt threshold.
    bus(0, 1, 2'd2, 32'h4, 0, 0, 0);
    for (int i = 0; i < IRQ_LEVEL; i++) begin
      push_word(DATA_SIZE'(i), 0);
      check("irq fill", 32'(irq), (i == IRQ_LEVEL - 1) ? 32'(IRQ_BUILT) : 32'h0);
    end
    read_expect("irq pop", 2'd0, 32'h8000_0000);
    check("irq drop", 32'(irq), 32'h0);
    read_expect("ien status", 2'd1, 32'h0008_0007);
    read_expect("ien control", 2'd2, 32'h0000_0004);
    bus(0, 1, 2'd3, 32'h0, 0, 0, 0);
    read_expect("frames cleared", 2'd3, 32'h0);
    bus(0, 1, 2'd2, 32'h2, 0, 0, 0);

    // Randomized traffic checked against the model every cycle.
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] wd;
      logic [1:0]  a;
      logic        rd, wr;
      reset = ($urandom_range(0, 299) == 0);
      a  = 2'($urandom);
      rd = ($urandom_range(0, 9) < 5);
      wr = ($urandom_range(0, 9) < 2);
      wd = $urandom;
      if (a == 2'd2 && $urandom_range(0, 7) != 0) wd[1] = 1'b0;
      if (a == 2'd3 && $urandom_range(0, 3) != 0) wr = 1'b0;
      bus(rd, wr, a, wd, ($urandom_range(0, 9) < 6), DATA_SIZE'($urandom),
          ($urandom_range(0, 7) == 0));
      reset = 0;
    end

    repeat (2) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
